sign_narrower_sat: RTL and testbench



---
 rtl/sign_pkg.sv | 31 +++
 rtl/sign_range_check.sv | 34 +++
 rtl/sign_narrower_sat.sv | 104 ++++++++++
 tb/tb_sign_narrower_sat.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sign_pkg.sv
// sign_pkg: shared types and helpers for signed narrowing stages (clamp/wrap selected by SIGN_NARROWER_SAT_EN).
package sign_pkg;

  // Widest word the helper functions can describe.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_t;

  // Largest positive value of a width-bit signed word: 0 then ones.
  function automatic logic [MAX_W-1:0] sat_max(input int width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // Most negative value of a width-bit signed word: 1 then zeros.
  function automatic logic [MAX_W-1:0] sat_min(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction

  // A word fits in out_w bits when its top in_w-out_w+1 bits all agree with the sign.
  function automatic logic in_range(input logic [MAX_W-1:0] data, input int in_w, input int out_w);
    logic ok;
    ok = 1'b1;
    for (int i = out_w - 1; i < in_w; i++) ok = ok && (data[i] == data[in_w-1]);
    return ok;
  endfunction

endpackage

// File: rtl/sign_range_check.sv
// sign_range_check: combinational range check and clamp/wrap of a signed word; clamps when SIGN_NARROWER_SAT_EN is defined, truncates otherwise.
module sign_range_check
  import sign_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 8
) (
  input  logic [INPUT_WIDTH-1:0]  i_data,
  output logic [OUTPUT_WIDTH-1:0] o_data,
  output logic                    o_sat
);

  if (OUTPUT_WIDTH < 2 || OUTPUT_WIDTH >= INPUT_WIDTH || INPUT_WIDTH > MAX_W) begin : g_bad_width
    $error("sign_range_check: need 2 <= OUTPUT_WIDTH < INPUT_WIDTH <= %0d", MAX_W);
  end

  logic [MAX_W-1:0] w_ext;

  assign w_ext = MAX_W'(i_data);
  assign o_sat = !in_range(w_ext, INPUT_WIDTH, OUTPUT_WIDTH);

`ifdef SIGN_NARROWER_SAT_EN
  logic [MAX_W-1:0] w_max;
  logic [MAX_W-1:0] w_min;

  assign w_max  = sat_max(OUTPUT_WIDTH);
  assign w_min  = sat_min(OUTPUT_WIDTH);
  assign o_data = !o_sat ? i_data[OUTPUT_WIDTH-1:0] :
                  i_data[INPUT_WIDTH-1] ? w_min[OUTPUT_WIDTH-1:0] : w_max[OUTPUT_WIDTH-1:0];
`else
  assign o_data = i_data[OUTPUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/sign_narrower_sat.sv
// sign_narrower_sat: streaming signed narrower with 2-entry skid buffer and sticky overflow counter; SIGN_NARROWER_SAT_EN selects clamp instead of wrap.
module sign_narrower_sat
  import sign_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_sat,
  output logic [CNT_WIDTH-1:0]    sat_count,
  input  logic                    clr_count
);

  if (OUTPUT_WIDTH < 2 || OUTPUT_WIDTH >= INPUT_WIDTH) begin : g_bad_width
    $error("sign_narrower_sat: need 2 <= OUTPUT_WIDTH < INPUT_WIDTH");
  end

  skid_state_t             r_state;
  skid_state_t             w_next;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [OUTPUT_WIDTH-1:0] r_out_data;
  logic                    r_out_sat;
  logic [OUTPUT_WIDTH-1:0] r_skid_data;
  logic                    r_skid_sat;
  logic [CNT_WIDTH-1:0]    r_sat_count;
  logic [OUTPUT_WIDTH-1:0] w_data;
  logic                    w_sat;
  logic                    w_acc;
  logic                    w_emit;

  sign_range_check #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_check (
    .i_data(in_data),
    .o_data(w_data),
    .o_sat (w_sat)
  );

  assign w_acc  = in_valid && r_in_ready;
  assign w_emit = r_out_valid && out_ready;

  // Skid occupancy transitions; TWO never sees an accept because in_ready is low there.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: w_next = w_acc ? ST_ONE : ST_EMPTY;
      ST_ONE:   w_next = (w_acc && !w_emit) ? ST_TWO : (!w_acc && w_emit) ? ST_EMPTY : ST_ONE;
      ST_TWO:   w_next = w_emit ? ST_ONE : ST_TWO;
      default:  w_next = ST_EMPTY;
    endcase
  end

  // State, handshake flags and the output/skid registers; the output register only changes when empty or on emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_skid_data <= '0;
      r_skid_sat  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next != ST_TWO);
      r_out_valid <= (w_next != ST_EMPTY);
      if (r_state == ST_TWO && w_emit) begin
        r_out_data <= r_skid_data;
        r_out_sat  <= r_skid_sat;
      end else if (w_acc && (r_state == ST_EMPTY || w_emit)) begin
        r_out_data <= w_data;
        r_out_sat  <= w_sat;
      end
      if (w_acc && r_state == ST_ONE && !w_emit) begin
        r_skid_data <= w_data;
        r_skid_sat  <= w_sat;
      end
    end
  end

  // Sticky overflow counter: counts at acceptance, saturates at all-ones, clear wins over old value but not the new event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sat_count <= '0;
    else if (clr_count) r_sat_count <= (w_acc && w_sat) ? CNT_WIDTH'(1) : '0;
    else if (w_acc && w_sat && r_sat_count != '1) r_sat_count <= r_sat_count + CNT_WIDTH'(1);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_sign_narrower_sat.sv
// tb_sign_narrower_sat: directed checks of narrowing, overflow flagging, skid backpressure, counter edges and async reset.
module tb_sign_narrower_sat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sat;
  logic [15:0] sat_count;
  logic        clr_count = 1'b0;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [15:0] in_data2 = '0;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic        out_sat2;
  logic [1:0]  sat_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sign_narrower_sat dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_count(sat_count), .clr_count(clr_count)
  );

  sign_narrower_sat #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_sat(out_sat2),
    .sat_count(sat_count2), .clr_count(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word with out_ready high; it must appear on the next cycle.
  task automatic stream(input logic [15:0] d, input logic [7:0] exp_d, input logic exp_s, input string tag);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_d));
    chk({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    rst_n = 1'b1;
    tick();

    stream(16'h007F, 8'h7F, 1'b0, "in_7f");
    chk("in_ready_stream", 32'(in_ready), 32'd1);
    stream(16'hFF80, 8'h80, 1'b0, "in_ff80");
    stream(16'h0000, 8'h00, 1'b0, "in_0");
    stream(16'hFFFF, 8'hFF, 1'b0, "in_ffff");
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("cnt_inrange", 32'(sat_count), 32'd0);

`ifdef SIGN_NARROWER_SAT_EN
    stream(16'h0080, 8'h7F, 1'b1, "pos_0080");
    stream(16'h7FFF, 8'h7F, 1'b1, "pos_7fff");
`else
    stream(16'h0080, 8'h80, 1'b1, "pos_0080");
    stream(16'h7FFF, 8'hFF, 1'b1, "pos_7fff");
`endif
    in_valid = 1'b0;
    chk("cnt_pos", 32'(sat_count), 32'd2);
    tick();
`ifdef SIGN_NARROWER_SAT_EN
    stream(16'hFF7F, 8'h80, 1'b1, "neg_ff7f");
    stream(16'h8000, 8'h80, 1'b1, "neg_8000");
`else
    stream(16'hFF7F, 8'h7F, 1'b1, "neg_ff7f");
    stream(16'h8000, 8'h00, 1'b1, "neg_8000");
`endif
    in_valid = 1'b0;
    tick();
    chk("cnt_neg", 32'(sat_count), 32'd4);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    tick();
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    chk("bp_a_data", 32'(out_data), 32'h11);
    in_data = 16'h0022;
    tick();
    chk("bp_b_ready", 32'(in_ready), 32'd0);
    chk("bp_b_hold", 32'(out_data), 32'h11);
    in_data = 16'h0033;
    tick();
    chk("bp_c_ready", 32'(in_ready), 32'd0);
    chk("bp_c_hold", 32'(out_data), 32'h11);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_b", 32'(out_data), 32'h22);
    chk("bp_drain_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drain_c", 32'(out_data), 32'h33);
    chk("bp_drain_c_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(sat_count), 32'd4);

    in_valid  = 1'b1;
    in_data   = 16'h0100;
    clr_count = 1'b1;
    tick();
    chk("clr_with_ovf", 32'(sat_count), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("clr_alone", 32'(sat_count), 32'd0);
    clr_count = 1'b0;
    tick();

    in_valid2 = 1'b1;
    in_data2  = 16'h0100;
    tick();
    tick();
    chk("cnt2_two", 32'(sat_count2), 32'd2);
    tick();
    chk("cnt2_three", 32'(sat_count2), 32'd3);
    tick();
    tick();
    in_valid2 = 1'b0;
    chk("cnt2_stick", 32'(sat_count2), 32'd3);
    tick();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    tick();
    in_data = 16'h0200;
    tick();
    in_valid = 1'b0;
    chk("two_ready", 32'(in_ready), 32'd0);
    chk("two_cnt", 32'(sat_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_cnt", 32'(sat_count), 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    stream(16'h0042, 8'h42, 1'b0, "post_rst");
    in_valid = 1'b0;
    tick();
    chk("post_rst_alone", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
